// File: rtl/audio_sample_feeder.sv
// PCM sample FIFO feeding the PWM generator: releases one attenuated,
// offset-binary 12-bit sample per output period and flags underruns.
module audio_sample_feeder #(
  parameter int DEPTH  = 512,
  parameter int PERIOD = 4536
) (
  input  logic                     clk_200mhz,
  input  logic                     rst,
  input  logic signed [15:0]       s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     enable,
  input  logic [3:0]               vol_shift,
  input  logic                     clr_underrun,
  output logic [11:0]              pcm_out,
  output logic                     sample_tick,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     low_water,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PERIOD);

  function automatic logic [11:0] to_pcm(input logic signed [15:0] x,
                                         input logic [3:0] sh);
    logic signed [15:0] s;
    s = x >>> sh;
    return {~s[15], s[14:4]};
  endfunction

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [11:0]        pcm_q, pcm_d;
  logic               tick_q, underrun_q, underrun_d, low_water_q;
  logic signed [15:0] mem_q [DEPTH];
  logic signed [15:0] head_q;
  logic               period_end, push, pop, starve;

  assign s_ready = (level_q != LW'(DEPTH));

  always_comb begin
    period_end = enable && (cnt_q == CW'(PERIOD - 1));
    push       = s_valid && s_ready;
    pop        = period_end && (level_q != '0);
    starve     = period_end && (level_q == '0);
    cnt_d      = (!enable || period_end) ? '0 : cnt_q + 1'b1;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    // A starve in the same cycle as a clear must leave the flag set.
    underrun_d = starve ? 1'b1 : (clr_underrun ? 1'b0 : underrun_q);
    pcm_d      = pcm_q;
    if (!enable || starve) pcm_d = 12'h800;
    else if (pop)          pcm_d = to_pcm(head_q, vol_shift);
  end

  always_ff @(posedge clk_200mhz) begin
    if (rst) begin
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pcm_q       <= 12'h800;
      tick_q      <= 1'b0;
      underrun_q  <= 1'b0;
      low_water_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pcm_q       <= pcm_d;
      tick_q      <= period_end;
      underrun_q  <= underrun_d;
      low_water_q <= (level_q < LW'(DEPTH / 4));
    end
  end

  // Registered RAM read of the next head; a write to that same address
  // is forwarded so the head is never stale when the pop comes.
  always_ff @(posedge clk_200mhz) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
    head_q <= (push && (wr_ptr_q == rd_ptr_d)) ? s_data : mem_q[rd_ptr_d];
  end

  assign pcm_out     = pcm_q;
  assign sample_tick = tick_q;
  assign level       = level_q;
  assign low_water   = low_water_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder: tick timing, conversion, underrun,
// full-FIFO backpressure and mid-playback reset.
`timescale 1ns/1ps
module tb_audio_sample_feeder;
  localparam int DEPTH  = 512;
  localparam int PERIOD = 4536;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk_200mhz = 1'b0;
  logic              rst = 1'b1;
  logic signed [15:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              enable = 1'b0;
  logic [3:0]        vol_shift = '0;
  logic              clr_underrun = 1'b0;
  logic [11:0]       pcm_out;
  logic              sample_tick;
  logic [LW-1:0]     level;
  logic              low_water;
  logic              underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #2.5 clk_200mhz = ~clk_200mhz;

  audio_sample_feeder #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk_200mhz  (clk_200mhz),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .enable      (enable),
    .vol_shift   (vol_shift),
    .clr_underrun(clr_underrun),
    .pcm_out     (pcm_out),
    .sample_tick (sample_tick),
    .level       (level),
    .low_water   (low_water),
    .underrun    (underrun)
  );

  task automatic step();
    @(posedge clk_200mhz);
    #1;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sample_tick !== 1'b1 && n < PERIOD + 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    run(3);
    chk("rst_pcm",      32'(pcm_out), 32'h800);
    chk("rst_tick",     32'(sample_tick), 32'd0);
    chk("rst_level",    32'(level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ready",    32'(s_ready), 32'd1);

    // Three full-scale samples, vol_shift 0
    rst = 1'b0; enable = 1'b1; vol_shift = 4'd0;
    s_valid = 1'b1; s_data = 16'sh7FFF; step();
    s_data = 16'sh0000; step();
    s_data = 16'sh8000; step();
    s_valid = 1'b0;
    chk("t1_level3", 32'(level), 32'd3);
    chk("t1_lowwater", 32'(low_water), 32'd1);
    wait_tick(n);
    chk("t1_first_tick", 32'(n + 3), 32'(PERIOD));
    chk("t1_pcm_7fff", 32'(pcm_out), 32'hFFF);
    chk("t1_level2", 32'(level), 32'd2);
    step();
    chk("t1_tick_pulse", 32'(sample_tick), 32'd0);
    wait_tick(n);
    chk("t1_interval2", 32'(n + 1), 32'(PERIOD));
    chk("t1_pcm_0000", 32'(pcm_out), 32'h800);
    chk("t1_level1", 32'(level), 32'd1);
    step();
    wait_tick(n);
    chk("t1_interval3", 32'(n + 1), 32'(PERIOD));
    chk("t1_pcm_8000", 32'(pcm_out), 32'h000);
    chk("t1_level0", 32'(level), 32'd0);

    // Attenuation: 0x4000 >>> 2 = 0x1000 -> 0x900
    vol_shift = 4'd2; s_valid = 1'b1; s_data = 16'sh4000; step();
    s_valid = 1'b0;
    wait_tick(n);
    chk("t2_interval", 32'(n + 1), 32'(PERIOD));
    chk("t2_pcm_shift2", 32'(pcm_out), 32'h900);
    run(10);
    vol_shift = 4'd0; s_valid = 1'b1; s_data = 16'sh8000; step();
    s_valid = 1'b0;
    run(1000);
    chk("t2_vol_hold", 32'(pcm_out), 32'h900);
    // 0x8000 >>> 15 = 0xFFFF -> 0x7FF
    vol_shift = 4'd15;
    wait_tick(n);
    chk("t2_interval2", 32'(n + 1011), 32'(PERIOD));
    chk("t2_pcm_shift15", 32'(pcm_out), 32'h7FF);

    // Drain to empty
    chk("t3_no_underrun", 32'(underrun), 32'd0);
    wait_tick(n);
    chk("t3_interval", 32'(n), 32'(PERIOD));
    chk("t3_silence", 32'(pcm_out), 32'h800);
    chk("t3_underrun", 32'(underrun), 32'd1);
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    chk("t3_cleared", 32'(underrun), 32'd0);
    run(PERIOD - 2);
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    chk("t3_tick_on_clr", 32'(sample_tick), 32'd1);
    chk("t3_set_wins", 32'(underrun), 32'd1);

    // Push into empty FIFO on the pop cycle
    vol_shift = 4'd0;
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    chk("t5_cleared", 32'(underrun), 32'd0);
    run(PERIOD - 2);
    s_valid = 1'b1; s_data = 16'sh1230; step();
    s_valid = 1'b0;
    chk("t5_tick", 32'(sample_tick), 32'd1);
    chk("t5_silence", 32'(pcm_out), 32'h800);
    chk("t5_underrun", 32'(underrun), 32'd1);
    chk("t5_kept", 32'(level), 32'd1);
    wait_tick(n);
    chk("t5_interval", 32'(n), 32'(PERIOD));
    chk("t5_pcm", 32'(pcm_out), 32'h923);
    chk("t5_level0", 32'(level), 32'd0);

    // Reset mid-playback with 100 samples queued
    s_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 16'(i * 256);
      step();
    end
    s_valid = 1'b0;
    run(1900);
    chk("t6_level100", 32'(level), 32'd100);
    chk("t6_pcm_before", 32'(pcm_out), 32'h923);
    rst = 1'b1; step();
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_pcm", 32'(pcm_out), 32'h800);
    chk("t6_tick", 32'(sample_tick), 32'd0);
    chk("t6_underrun", 32'(underrun), 32'd0);
    chk("t6_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    wait_tick(n);
    chk("t6_first_tick", 32'(n), 32'(PERIOD));
    chk("t6_empty_tick", 32'(underrun), 32'd1);

    // Fill to DEPTH with s_valid held
    s_valid = 1'b1;
    for (int i = 0; i < DEPTH + 20; i++) begin
      s_data = 16'(16'h2000 + i * 16);
      step();
    end
    chk("t4_full", 32'(level), 32'(DEPTH));
    chk("t4_ready_low", 32'(s_ready), 32'd0);
    chk("t4_lowwater_off", 32'(low_water), 32'd0);
    wait_tick(n);
    chk("t4_interval", 32'(n + DEPTH + 20), 32'(PERIOD));
    chk("t4_pcm", 32'(pcm_out), 32'hA00);
    chk("t4_level511", 32'(level), 32'(DEPTH - 1));
    chk("t4_ready_high", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    chk("t4_refull", 32'(level), 32'(DEPTH));
    chk("t4_ready_low2", 32'(s_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
